// File: rtl/udma_stream_writer.sv
// rtl/udma_stream_writer.sv - stream-to-L2 circular buffer writer with spoof mirror
module udma_stream_writer #(
  parameter int unsigned L2_AWIDTH_NOAL  = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned STREAM_ID_WIDTH = 2,
  parameter int unsigned INST_ID         = 0,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_clr_i,
  input  logic                       cfg_en_i,
  input  logic [L2_AWIDTH_NOAL-1:0]  cfg_base_i,
  input  logic [L2_AWIDTH_NOAL-1:0]  cfg_size_i,
  input  logic [DATA_WIDTH-1:0]      in_stream_data_i,
  input  logic [1:0]                 in_stream_datasize_i,
  input  logic                       in_stream_valid_i,
  input  logic                       in_stream_sot_i,
  input  logic                       in_stream_eot_i,
  output logic                       in_stream_ready_o,
  output logic                       rx_ch_req_o,
  output logic [L2_AWIDTH_NOAL-1:0]  rx_ch_addr_o,
  output logic [1:0]                 rx_ch_datasize_o,
  output logic [DATA_WIDTH-1:0]      rx_ch_data_o,
  input  logic                       rx_ch_gnt_i,
  output logic                       spoof_req_o,
  output logic                       spoof_gnt_o,
  output logic [L2_AWIDTH_NOAL-1:0]  spoof_addr_o,
  output logic [STREAM_ID_WIDTH-1:0] spoof_dest_o,
  output logic [1:0]                 spoof_datasize_o,
  output logic                       done_o,
  output logic                       wrap_o,
  output logic                       err_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = L2_AWIDTH_NOAL;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            size;
    logic                  sot;
    logic                  eot;
  } entry_t;

  state_e        state_q;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] r_ptr_q, r_ptr_d;
  logic [AW-1:0] r_off_q, r_off_d;
  logic          done_q, done_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic          fifo_empty, fifo_full;
  logic          active, ready, accept, push, bad_beat, req, grant;
  logic [AW-1:0] eff_addr, eff_off, nb, off_next;
  logic          wrap_hit;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  // ready uses only registered FIFO state, so a full FIFO never sees push+pop together
  assign ready    = !fifo_full && cfg_en_i && (state_q == ST_RUN) && !cmd_clr_i;
  assign accept   = in_stream_valid_i && ready;
  assign bad_beat = accept && (in_stream_datasize_i == 2'b11);
  assign push     = accept && (in_stream_datasize_i != 2'b11);
  assign req      = active && !fifo_empty;
  assign grant    = req && rx_ch_gnt_i;

  // A start-of-transfer beat restarts at the buffer base with a zero offset
  always_comb begin
    eff_addr = head.sot ? cfg_base_i : r_ptr_q;
    eff_off  = head.sot ? '0 : r_off_q;
    case (head.size)
      2'b00:   nb = AW'(1);
      2'b01:   nb = AW'(2);
      default: nb = AW'(4);
    endcase
    off_next = eff_off + nb;
    wrap_hit = (cfg_size_i != '0) && (off_next >= cfg_size_i);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    r_ptr_d  = r_ptr_q;
    r_off_d  = r_off_q;
    done_d   = grant && head.eot;
    wrap_d   = grant && wrap_hit;
    err_d    = err_q || bad_beat;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (grant) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, grant})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if ((state_q == ST_IDLE) && cfg_en_i) begin
      r_ptr_d = cfg_base_i;
      r_off_d = '0;
    end else if (grant) begin
      if (wrap_hit) begin
        r_ptr_d = cfg_base_i;
        r_off_d = '0;
      end else begin
        r_ptr_d = eff_addr + nb;
        r_off_d = off_next;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || cmd_clr_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      r_ptr_q  <= '0;
      r_off_q  <= '0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      r_ptr_q  <= r_ptr_d;
      r_off_q  <= r_off_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      case (state_q)
        ST_IDLE:  if (cfg_en_i)   state_q <= ST_RUN;
        ST_RUN:   if (!cfg_en_i)  state_q <= ST_DRAIN;
        ST_DRAIN: if (fifo_empty) state_q <= ST_IDLE;
        default:                  state_q <= ST_IDLE;
      endcase
    end
  end

  // Storage is not reset; the pointers and count define which entries are live
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: in_stream_data_i, size: in_stream_datasize_i,
                           sot: in_stream_sot_i, eot: in_stream_eot_i};
    end
  end

  assign in_stream_ready_o = ready;
  assign rx_ch_req_o       = req;
  assign rx_ch_addr_o      = req ? eff_addr : '0;
  assign rx_ch_datasize_o  = req ? head.size : 2'b00;
  assign rx_ch_data_o      = req ? head.data : '0;

  assign spoof_req_o      = req;
  assign spoof_gnt_o      = grant;
  assign spoof_addr_o     = rx_ch_addr_o;
  assign spoof_dest_o     = STREAM_ID_WIDTH'(INST_ID);
  assign spoof_datasize_o = rx_ch_datasize_o;

  assign done_o = done_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_udma_stream_writer.sv
// tb/tb_udma_stream_writer.sv - table, directed and random checks of udma_stream_writer
module tb_udma_stream_writer;

  logic        clk;
  logic        rst_i, cmd_clr_i, cfg_en_i;
  logic [15:0] cfg_base_i, cfg_size_i;
  logic [31:0] in_stream_data_i;
  logic [1:0]  in_stream_datasize_i;
  logic        in_stream_valid_i, in_stream_sot_i, in_stream_eot_i, in_stream_ready_o;
  logic        rx_ch_req_o, rx_ch_gnt_i;
  logic [15:0] rx_ch_addr_o;
  logic [1:0]  rx_ch_datasize_o;
  logic [31:0] rx_ch_data_o;
  logic        spoof_req_o, spoof_gnt_o;
  logic [15:0] spoof_addr_o;
  logic [1:0]  spoof_dest_o, spoof_datasize_o;
  logic        done_o, wrap_o, err_o;

  udma_stream_writer dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_clr_i(cmd_clr_i), .cfg_en_i(cfg_en_i),
    .cfg_base_i(cfg_base_i), .cfg_size_i(cfg_size_i),
    .in_stream_data_i(in_stream_data_i), .in_stream_datasize_i(in_stream_datasize_i),
    .in_stream_valid_i(in_stream_valid_i), .in_stream_sot_i(in_stream_sot_i),
    .in_stream_eot_i(in_stream_eot_i), .in_stream_ready_o(in_stream_ready_o),
    .rx_ch_req_o(rx_ch_req_o), .rx_ch_addr_o(rx_ch_addr_o),
    .rx_ch_datasize_o(rx_ch_datasize_o), .rx_ch_data_o(rx_ch_data_o),
    .rx_ch_gnt_i(rx_ch_gnt_i), .spoof_req_o(spoof_req_o), .spoof_gnt_o(spoof_gnt_o),
    .spoof_addr_o(spoof_addr_o), .spoof_dest_o(spoof_dest_o),
    .spoof_datasize_o(spoof_datasize_o), .done_o(done_o), .wrap_o(wrap_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted legal beat becomes an expected write whose
  // address is fixed by the sequence of beats since the last base reload.
  typedef struct {
    logic [15:0] addr;
    logic [1:0]  dsz;
    logic [31:0] data;
    logic        eot;
    logic        wrap;
  } wr_t;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
  wr_t         q[$];
  int          ms = M_IDLE;
  logic [15:0] mptr = 16'h0, moff = 16'h0;
  logic        m_done = 1'b0, m_wrap = 1'b0, m_err = 1'b0;

  task automatic model_check();
    logic er, erdy;
    logic [15:0] ea;
    logic [31:0] ed;
    logic [1:0]  es;
    er   = (ms != M_IDLE) && (q.size() != 0);
    erdy = (ms == M_RUN) && cfg_en_i && !cmd_clr_i && (q.size() < 4);
    ea = 16'h0; ed = 32'h0; es = 2'b00;
    if (er) begin
      ea = q[0].addr; ed = q[0].data; es = q[0].dsz;
    end
    check("ready", in_stream_ready_o, erdy);
    check("req", rx_ch_req_o, er);
    check("addr", rx_ch_addr_o, ea);
    check("data", rx_ch_data_o, ed);
    check("dsz", rx_ch_datasize_o, es);
    check("spoof_req", spoof_req_o, er);
    check("spoof_gnt", spoof_gnt_o, er && rx_ch_gnt_i);
    check("spoof_addr", spoof_addr_o, ea);
    check("spoof_dsz", spoof_datasize_o, es);
    check("spoof_dest", spoof_dest_o, 2'd0);
    check("done", done_o, m_done);
    check("wrap", wrap_o, m_wrap);
    check("err", err_o, m_err);
  endtask

  task automatic model_update();
    int qs;
    logic acc, gr;
    logic [15:0] ea, eo, nb, offn;
    wr_t w;
    if (rst_i || cmd_clr_i) begin
      q.delete(); ms = M_IDLE; m_done = 0; m_wrap = 0; m_err = 0;
      return;
    end
    qs  = q.size();
    acc = in_stream_valid_i && (ms == M_RUN) && cfg_en_i && (qs < 4);
    gr  = (ms != M_IDLE) && (qs > 0) && rx_ch_gnt_i;
    m_done = 0; m_wrap = 0;
    if (gr) begin
      m_done = q[0].eot; m_wrap = q[0].wrap;
      void'(q.pop_front());
    end
    if (acc) begin
      if (in_stream_datasize_i == 2'b11) m_err = 1;
      else begin
        ea = in_stream_sot_i ? cfg_base_i : mptr;
        eo = in_stream_sot_i ? 16'h0 : moff;
        nb = (in_stream_datasize_i == 2'b00) ? 16'd1 : (in_stream_datasize_i == 2'b01) ? 16'd2 : 16'd4;
        offn = eo + nb;
        w.addr = ea; w.dsz = in_stream_datasize_i; w.data = in_stream_data_i;
        w.eot = in_stream_eot_i;
        w.wrap = (cfg_size_i != 0) && (offn >= cfg_size_i);
        if (w.wrap) begin mptr = cfg_base_i; moff = 0; end
        else begin mptr = ea + nb; moff = offn; end
        q.push_back(w);
      end
    end
    case (ms)
      M_IDLE:  if (cfg_en_i) begin ms = M_RUN; mptr = cfg_base_i; moff = 0; end
      M_RUN:   if (!cfg_en_i) ms = M_DRAIN;
      default: if (qs == 0) ms = M_IDLE;
    endcase
  endtask

  int          dut_wr = 0, dut_done = 0, dut_wrap = 0, dut_acc = 0;
  logic [15:0] wlog[$];

  task automatic observe();
    if (rx_ch_req_o && rx_ch_gnt_i) begin dut_wr++; wlog.push_back(rx_ch_addr_o); end
    if (done_o) dut_done++;
    if (wrap_o) dut_wrap++;
    if (in_stream_valid_i && in_stream_ready_o) dut_acc++;
  endtask

  logic        n_rst = 1, n_clr = 0, n_en = 0;
  logic [15:0] n_base = 0, n_size = 0;

  task automatic step(input logic v, input logic [1:0] ds, input logic s, input logic e, input logic g);
    @(negedge clk);
    rst_i = n_rst; cmd_clr_i = n_clr; cfg_en_i = n_en; cfg_base_i = n_base; cfg_size_i = n_size;
    in_stream_valid_i = v; in_stream_datasize_i = ds; in_stream_sot_i = s; in_stream_eot_i = e;
    in_stream_data_i = $urandom; rx_ch_gnt_i = g;
    #1;
    model_check();
    observe();
    model_update();
  endtask

  typedef struct {
    logic [15:0] base, size;
    logic        v, s, e, g;
    logic [31:0] d;
    logic        rdy, req;
    logic [15:0] addr;
    logic [31:0] od;
    logic        dn, wr;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] base, input logic [15:0] size, input logic v,
                              input logic s, input logic e, input logic [31:0] d, input logic rdy,
                              input logic req, input logic [15:0] addr, input logic [31:0] od,
                              input logic dn, input logic wr);
    vec_t t;
    t.base = base; t.size = size; t.v = v; t.s = s; t.e = e; t.g = 1'b1; t.d = d;
    t.rdy = rdy; t.req = req; t.addr = addr; t.od = od; t.dn = dn; t.wr = wr;
    return t;
  endfunction

  localparam int NV = 17;
  vec_t tv[NV];
  int   sizes[5] = '{0, 6, 8, 12, 32};
  int   a0, w0, d0;

  initial begin
    tv[0]  = mk(16'h100, 0, 0, 0, 0, 0,            0, 0, 16'h000, 0,            0, 0);
    tv[1]  = mk(16'h100, 0, 1, 1, 0, 32'hA0000000, 1, 0, 16'h000, 0,            0, 0);
    tv[2]  = mk(16'h100, 0, 1, 0, 0, 32'hA0000001, 1, 1, 16'h100, 32'hA0000000, 0, 0);
    tv[3]  = mk(16'h100, 0, 1, 0, 0, 32'hA0000002, 1, 1, 16'h104, 32'hA0000001, 0, 0);
    tv[4]  = mk(16'h100, 0, 1, 0, 1, 32'hA0000003, 1, 1, 16'h108, 32'hA0000002, 0, 0);
    tv[5]  = mk(16'h100, 0, 0, 0, 0, 0,            1, 1, 16'h10C, 32'hA0000003, 0, 0);
    tv[6]  = mk(16'h100, 0, 0, 0, 0, 0,            1, 0, 16'h000, 0,            1, 0);
    tv[7]  = mk(16'h100, 0, 0, 0, 0, 0,            1, 0, 16'h000, 0,            0, 0);
    tv[8]  = mk(16'h200, 8, 1, 1, 0, 32'hB0000000, 1, 0, 16'h000, 0,            0, 0);
    tv[9]  = mk(16'h200, 8, 1, 0, 0, 32'hB0000001, 1, 1, 16'h200, 32'hB0000000, 0, 0);
    tv[10] = mk(16'h200, 8, 1, 0, 0, 32'hB0000002, 1, 1, 16'h204, 32'hB0000001, 0, 0);
    tv[11] = mk(16'h200, 8, 1, 0, 0, 32'hB0000003, 1, 1, 16'h200, 32'hB0000002, 0, 1);
    tv[12] = mk(16'h200, 8, 1, 0, 0, 32'hB0000004, 1, 1, 16'h204, 32'hB0000003, 0, 0);
    tv[13] = mk(16'h200, 8, 1, 0, 1, 32'hB0000005, 1, 1, 16'h200, 32'hB0000004, 0, 1);
    tv[14] = mk(16'h200, 8, 0, 0, 0, 0,            1, 1, 16'h204, 32'hB0000005, 0, 0);
    tv[15] = mk(16'h200, 8, 0, 0, 0, 0,            1, 0, 16'h000, 0,            1, 1);
    tv[16] = mk(16'h200, 8, 0, 0, 0, 0,            1, 0, 16'h000, 0,            0, 0);

    rst_i = 1; cmd_clr_i = 0; cfg_en_i = 0; cfg_base_i = 0; cfg_size_i = 0;
    in_stream_data_i = 0; in_stream_datasize_i = 0; in_stream_valid_i = 0;
    in_stream_sot_i = 0; in_stream_eot_i = 0; rx_ch_gnt_i = 0;

    // reset: every output at zero
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // table: 4-beat linear transfer, then 6-beat transfer wrapping in an 8-byte buffer
    d0 = dut_done; w0 = dut_wrap;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_i = 0; cmd_clr_i = 0; cfg_en_i = 1; cfg_base_i = tv[i].base; cfg_size_i = tv[i].size;
      in_stream_valid_i = tv[i].v; in_stream_datasize_i = 2'b10; in_stream_sot_i = tv[i].s;
      in_stream_eot_i = tv[i].e; in_stream_data_i = tv[i].d; rx_ch_gnt_i = tv[i].g;
      #1;
      check("t_ready", in_stream_ready_o, tv[i].rdy);
      check("t_req", rx_ch_req_o, tv[i].req);
      check("t_addr", rx_ch_addr_o, tv[i].addr);
      check("t_data", rx_ch_data_o, tv[i].od);
      check("t_spoof_addr", spoof_addr_o, tv[i].addr);
      check("t_spoof_gnt", spoof_gnt_o, tv[i].req);
      check("t_done", done_o, tv[i].dn);
      check("t_wrap", wrap_o, tv[i].wr);
      check("t_err", err_o, 1'b0);
      observe();
      model_update();
    end
    check("t_done_cnt", dut_done - d0, 2);
    check("t_wrap_cnt", dut_wrap - w0, 3);

    // FIFO full with grant held low, then drained with no loss
    n_rst = 0; n_en = 1; n_base = 16'h400; n_size = 0;
    a0 = dut_acc; w0 = dut_wr; d0 = dut_done;
    for (int i = 0; i < 6; i++) step(1, 2'b10, i == 0, 0, 0);
    check("full_acc", dut_acc - a0, 4);
    check("full_rdy", in_stream_ready_o, 0);
    step(1, 2'b10, 0, 1, 1);
    step(1, 2'b10, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    check("full_acc5", dut_acc - a0, 5);
    check("full_wr", dut_wr - w0, 5);
    check("full_done", dut_done - d0, 1);

    // mixed sizes, then an illegal-size beat
    n_base = 16'h300;
    wlog.delete(); w0 = dut_wr;
    step(1, 2'b00, 1, 0, 1);
    step(1, 2'b01, 0, 0, 1);
    step(1, 2'b10, 0, 0, 1);
    step(1, 2'b11, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    check("mix_wr", dut_wr - w0, 3);
    check("mix_a0", wlog.size() > 0 ? wlog[0] : 16'hDEAD, 16'h300);
    check("mix_a1", wlog.size() > 1 ? wlog[1] : 16'hDEAD, 16'h301);
    check("mix_a2", wlog.size() > 2 ? wlog[2] : 16'hDEAD, 16'h303);
    check("mix_err", err_o, 1);

    // clear with two beats buffered
    step(1, 2'b10, 0, 0, 0);
    step(1, 2'b10, 0, 0, 0);
    n_clr = 1; n_base = 16'h600;
    step(1, 2'b10, 0, 0, 1);
    n_clr = 0;
    step(0, 0, 0, 0, 1);
    check("clr_err", err_o, 0);
    check("clr_req", rx_ch_req_o, 0);

    // drop enable with 3 beats buffered, drain, restart at a new base
    w0 = dut_wr;
    for (int i = 0; i < 3; i++) step(1, 2'b10, i == 0, 0, 0);
    n_en = 0;
    step(1, 2'b10, 0, 0, 0);
    check("drain_rdy", in_stream_ready_o, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    check("drain_wr", dut_wr - w0, 3);
    n_base = 16'h540; n_en = 1;
    step(0, 0, 0, 0, 0);
    wlog.delete();
    step(1, 2'b10, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("restart_addr", wlog.size() > 0 ? wlog[0] : 16'hDEAD, 16'h540);

    // random traffic: first around the top of the address space, then random buffers
    for (int r = 0; r < 5; r++) begin
      n_clr = 1; n_en = 1;
      n_base = (r == 0) ? 16'hFFF0 : 16'($urandom);
      n_size = 16'(sizes[r]);
      step(0, 0, 0, 0, 0);
      n_clr = 0;
      for (int i = 0; i < 200; i++) begin
        int unsigned rs;
        logic [1:0] ds;
        rs = $urandom % 20;
        ds = (rs == 0) ? 2'b11 : 2'(rs % 3);
        if ($urandom % 50 == 0) n_en = !n_en;
        step(($urandom % 10) < 7, ds, ($urandom % 10) == 0, ($urandom % 7) == 0, ($urandom % 10) < 6);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
